mux_sel_pipe: RTL and testbench

//   Parametrised N-to-1 datapath select stage with a registered, flow-controlled output.

---
 rtl/mux_sel_pipe.sv | 138 +++++++++++++
 tb/tb_mux_sel_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: N-to-1 select stage with a registered, valid/ready output and a
// one-entry skid register. An out-of-range select produces zero data, sets sel_err
// on that beat and bumps a saturating counter when the beat is accepted.
module mux_sel_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned ERR_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [ERR_W-1:0]        err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   sel_data;
  logic               sel_oor;
  logic [WIDTH-1:0]   skid_data;
  logic               skid_err;
  logic               accept;
  logic               deliver;
  logic               load_out;
  logic               load_skid;
  logic               skid_to_out;

  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;
  assign out_valid = (state != EMPTY);

  // Select the addressed input; any code with no matching input yields zero and flags it.
  always_comb begin
    sel_data = '0;
    sel_oor  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_bus[k*WIDTH +: WIDTH];
        sel_oor  = 1'b0;
      end
    end
  end

  // Occupancy next-state and register load controls.
  always_comb begin
    state_nx    = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          state_nx = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_out = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nx  = TWO;
        end else if (deliver) begin
          state_nx = EMPTY;
        end
      end
      TWO: begin
        if (deliver) begin
          skid_to_out = 1'b1;
          state_nx    = ONE;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Occupancy state and registered ready; ready drops only when the skid will be full.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != TWO);
    end
  end

  // Output register: loaded from the mux directly or from the skid when it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= '0;
      sel_err <= 1'b0;
    end else if (load_out) begin
      out     <= sel_data;
      sel_err <= sel_oor;
    end else if (skid_to_out) begin
      out     <= skid_data;
      sel_err <= skid_err;
    end
  end

  // Skid register: holds the second beat while the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_data <= '0;
      skid_err  <= 1'b0;
    end else if (load_skid) begin
      skid_data <= sel_data;
      skid_err  <= sel_oor;
    end else if (skid_to_out) begin
      skid_data <= '0;
      skid_err  <= 1'b0;
    end
  end

  // Saturating count of accepted out-of-range selects.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept && sel_oor && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: directed beats pushed to a scoreboard at accept,
// popped and compared by an independent monitor at delivery.
module tb_mux_sel_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [95:0] in_bus = '0;
  logic [1:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sel_err;
  logic [7:0]  err_cnt;

  logic [95:0] s_bus = '0;
  logic [1:0]  s_sel = 2'd3;
  logic        s_valid = 1'b0;
  logic        s_in_ready;
  logic [31:0] s_out;
  logic        s_out_valid;
  logic        s_sel_err;
  logic [1:0]  s_err_cnt;

  mux_sel_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .ERR_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .err_cnt(err_cnt)
  );

  mux_sel_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_bus(s_bus), .sel(s_sel), .in_valid(s_valid),
    .in_ready(s_in_ready), .out(s_out), .out_valid(s_out_valid), .out_ready(1'b1),
    .sel_err(s_sel_err), .err_cnt(s_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mism = 0;
  int          cyc = 0;
  int          beat = 0;
  int unsigned exp_cnt = 0;
  bit          stall = 1'b0;
  logic [32:0] held = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every delivery and checks hold stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'({sel_err, out}), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'(out), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check("out_data", 64'(out), 64'(e.data));
          check("out_err", 64'(sel_err), 64'(e.err));
          if (e.lat) check("latency", 64'(cyc), 64'(e.acc + 1));
        end
      end
      stall = out_valid && !out_ready;
      held  = {sel_err, out};
    end
  end

  // One cycle of stimulus; exp_rdy < 0 means in_ready is not checked this cycle.
  task automatic step(input logic iv, input logic [1:0] s, input logic ordy,
                      input int exp_rdy, input bit lat);
    exp_t        e;
    logic [31:0] a, b, c;
    @(posedge clk); #1;
    beat++;
    a = 32'hA000_0000 + 32'(beat);
    b = 32'hB000_0000 + 32'(beat);
    c = 32'hC000_0000 + 32'(beat);
    in_bus    = {c, b, a};
    in_valid  = iv;
    sel       = s;
    out_ready = ordy;
    @(negedge clk);
    check("err_cnt", 64'(err_cnt), 64'(exp_cnt));
    if (exp_rdy >= 0) check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (iv && in_ready) begin
      e.data = (s == 2'd0) ? a : (s == 2'd1) ? b : (s == 2'd2) ? c : 32'h0;
      e.err  = (s == 2'd3);
      e.acc  = cyc;
      e.lat  = lat;
      sb.push_back(e);
      if (s == 2'd3 && exp_cnt != 255) exp_cnt++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_sel_err", 64'(sel_err), 64'd0);
    check("rst_sat_cnt", 64'(s_err_cnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Stream sel 0,1,2 with the output always ready.
    step(1, 2'd0, 1, 1, 1);
    step(1, 2'd1, 1, 1, 1);
    step(1, 2'd2, 1, 1, 1);
    step(0, 2'd0, 1, 1, 0);

    // Out-of-range select, then a valid one.
    step(1, 2'd3, 1, 1, 1);
    step(1, 2'd1, 1, 1, 1);
    step(0, 2'd0, 1, 1, 0);
    step(0, 2'd0, 1, 1, 0);

    // Stall: two beats fit, the third is refused until the output drains.
    step(1, 2'd0, 0, 1, 0);
    step(1, 2'd1, 0, 1, 0);
    step(1, 2'd2, 0, 0, 0);
    step(1, 2'd2, 0, 0, 0);
    step(0, 2'd0, 1, 0, 0);
    step(0, 2'd0, 1, 1, 0);
    step(0, 2'd0, 1, 1, 0);

    // Fill to two entries, then reset; both held beats must vanish.
    step(1, 2'd3, 0, 1, 0);
    step(1, 2'd1, 0, 1, 0);
    step(0, 2'd0, 0, 0, 0);
    do_reset();
    step(1, 2'd2, 1, 1, 1);
    step(0, 2'd0, 1, 1, 0);
    step(0, 2'd0, 1, 1, 0);

    // Irregular valid/ready traffic.
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), -1, 0);
    end
    for (int i = 0; i < 10; i++) begin
      if (sb.size() != 0) step(0, 2'd0, 1, -1, 0);
    end
    check("drained", 64'(sb.size()), 64'd0);

    // Two-bit error counter saturates at 3 after five out-of-range accepts.
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      s_valid = (k < 5);
      s_sel   = 2'd3;
      @(negedge clk);
      check("sat_cnt", 64'(s_err_cnt), 64'((k < 3) ? k : 3));
    end
    s_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
